// File: rtl/regfile_pkg.sv
// Shared widths and types for the 8-entry register file and its scoreboard.
// Every pipeline-register stage that carries a register address or operand uses these.
package regfile_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int ADDR_WIDTH = 3;
   localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

   typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [DATA_WIDTH-1:0] reg_data_t;

   localparam reg_addr_t ZERO_REG = '0;

   function automatic logic is_zero_reg(input reg_addr_t a);
      return a == ZERO_REG;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write bit per architectural register,
// plus the combinational stall request for the two decode source ports.
module reg_scoreboard #(
   parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_WIDTH-1:0]    raddr0,
   input  logic [ADDR_WIDTH-1:0]    raddr1,
   input  logic                     wen,
   input  logic [ADDR_WIDTH-1:0]    waddr,
   input  logic                     issue_en,
   input  logic [ADDR_WIDTH-1:0]    issue_addr,
   output logic [2**ADDR_WIDTH-1:0] busy,
   output logic                     hazard
);
   import regfile_pkg::*;

   localparam int NREG = 2 ** ADDR_WIDTH;

   logic [NREG-1:0] set_vec;
   logic [NREG-1:0] clr_vec;
   logic [NREG-1:0] busy_nxt;

   // A source stalls only if its producer is still pending and is not
   // completing this very cycle (the write-first bypass covers that case).
   function automatic logic src_hazard(
      input logic [ADDR_WIDTH-1:0] ra,
      input logic [NREG-1:0]       bv,
      input logic                  w,
      input logic [ADDR_WIDTH-1:0] wa
   );
      return (ra != '0) && bv[ra] && !(w && (wa == ra));
   endfunction

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (issue_en) set_vec[issue_addr] = 1'b1;
      if (wen)      clr_vec[waddr]      = 1'b1;
      set_vec[0] = 1'b0;
      clr_vec[0] = 1'b0;
      // Set overrides clear: a same-cycle issue means a newer write is in flight.
      busy_nxt = set_vec | (busy & ~clr_vec);
   end

   always_ff @(posedge clk) begin
      if (reset) busy <= '0;
      else       busy <= busy_nxt;
   end

   assign hazard = src_hazard(raddr0, busy, wen, waddr)
                 | src_hazard(raddr1, busy, wen, waddr);

endmodule

// File: rtl/regfile_8x64.sv
// Two-read, one-write register file with registered read data, write-first
// bypass, hard-wired zero register and a pending-write scoreboard.
module regfile_8x64 #(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_WIDTH-1:0]    raddr0,
   input  logic [ADDR_WIDTH-1:0]    raddr1,
   output logic [DATA_WIDTH-1:0]    rdata0,
   output logic [DATA_WIDTH-1:0]    rdata1,
   input  logic                     wen,
   input  logic [ADDR_WIDTH-1:0]    waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic                     issue_en,
   input  logic [ADDR_WIDTH-1:0]    issue_addr,
   output logic                     hazard,
   output logic [2**ADDR_WIDTH-1:0] busy
);
   import regfile_pkg::*;

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  wr_ok;
   logic [DATA_WIDTH-1:0] rd0_nxt;
   logic [DATA_WIDTH-1:0] rd1_nxt;
   logic [DATA_WIDTH-1:0] rdata0_p1;
   logic [DATA_WIDTH-1:0] rdata1_p1;

   function automatic logic [DATA_WIDTH-1:0] read_port(
      input logic [ADDR_WIDTH-1:0] ra,
      input logic                  w,
      input logic [ADDR_WIDTH-1:0] wa,
      input logic [DATA_WIDTH-1:0] wd,
      input logic [DATA_WIDTH-1:0] stored
   );
      if (ra == '0)             return '0;
      else if (w && (wa == ra)) return wd;
      else                      return stored;
   endfunction

   assign wr_ok   = wen && (waddr != '0);
   assign rd0_nxt = read_port(raddr0, wen, waddr, wdata, mem[raddr0]);
   assign rd1_nxt = read_port(raddr1, wen, waddr, wdata, mem[raddr1]);

   // ---- p0 -> p1: array update and operand capture ----
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rdata0_p1 <= '0;
         rdata1_p1 <= '0;
      end else begin
         if (wr_ok) mem[waddr] <= wdata;
         rdata0_p1 <= rd0_nxt;
         rdata1_p1 <= rd1_nxt;
      end
   end

   assign rdata0 = rdata0_p1;
   assign rdata1 = rdata1_p1;

   reg_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .raddr0     (raddr0),
      .raddr1     (raddr1),
      .wen        (wen),
      .waddr      (waddr),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .busy       (busy),
      .hazard     (hazard)
   );

endmodule

// File: tb/tb_regfile_8x64.sv
// Randomized plus directed bench for regfile_8x64 against an array-based
// reference of register contents and pending writes.
module tb_regfile_8x64;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  raddr0, raddr1, waddr, issue_addr;
   logic [63:0] rdata0, rdata1, wdata;
   logic        wen, issue_en, hazard;
   logic [7:0]  busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] ref_mem  [8];
   bit          ref_busy [8];
   logic [63:0] ref_rd0, ref_rd1;
   bit          model_valid = 0;

   regfile_8x64 dut (
      .clk        (clk),
      .reset      (reset),
      .raddr0     (raddr0),
      .raddr1     (raddr1),
      .rdata0     (rdata0),
      .rdata1     (rdata1),
      .wen        (wen),
      .waddr      (waddr),
      .wdata      (wdata),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .hazard     (hazard),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_busy_vec();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = ref_busy[i];
      return v;
   endfunction

   function automatic bit ref_hazard(input logic [2:0] r0, input logic [2:0] r1,
                                     input bit w, input logic [2:0] wa);
      bit h0, h1;
      h0 = (r0 != 0) && ref_busy[r0] && !(w && wa == r0);
      h1 = (r1 != 0) && ref_busy[r1] && !(w && wa == r1);
      return h0 || h1;
   endfunction

   // One clock: drive, check hazard before the edge, then update the model and
   // check registered outputs just after the edge.
   task automatic cycle(input bit rst, input bit w, input logic [2:0] wa, input logic [63:0] wd,
                        input bit ie, input logic [2:0] ia,
                        input logic [2:0] r0, input logic [2:0] r1);
      reset = rst; wen = w; waddr = wa; wdata = wd;
      issue_en = ie; issue_addr = ia; raddr0 = r0; raddr1 = r1;
      #1;
      if (model_valid && !rst)
         check("hazard", 64'(hazard), 64'(ref_hazard(r0, r1, w, wa)));
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 8; i++) begin ref_mem[i] = '0; ref_busy[i] = 0; end
         ref_rd0 = '0; ref_rd1 = '0;
         model_valid = 1;
      end else begin
         ref_rd0 = (r0 == 0) ? 64'd0 : ((w && wa == r0) ? wd : ref_mem[r0]);
         ref_rd1 = (r1 == 0) ? 64'd0 : ((w && wa == r1) ? wd : ref_mem[r1]);
         if (w && wa != 0) begin
            ref_mem[wa]  = wd;
            ref_busy[wa] = 0;
         end
         if (ie && ia != 0) ref_busy[ia] = 1;
      end
      #1;
      if (model_valid) begin
         check("rdata0", rdata0, ref_rd0);
         check("rdata1", rdata1, ref_rd1);
         check("busy",   64'(busy), 64'(ref_busy_vec()));
      end
   endtask

   initial begin
      // Reset, then read r1/r2.
      cycle(1, 0, 0, 0, 0, 0, 1, 2);
      cycle(1, 0, 0, 0, 0, 0, 1, 2);
      cycle(0, 0, 0, 0, 0, 0, 1, 2);
      check("reset_rdata0", rdata0, 64'd0);
      check("reset_busy", 64'(busy), 64'h00);
      check("reset_hazard", 64'(hazard), 64'd0);

      // Write r3, read it back.
      cycle(0, 1, 3, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 3, 0);
      check("r3_read", rdata0, 64'hDEAD_BEEF_0000_0001);

      // Same-cycle write and read of r5 (bypass).
      cycle(0, 1, 5, 64'h55, 0, 0, 0, 5);
      check("r5_bypass", rdata1, 64'h55);

      // r0 is hard-wired zero, issue to r0 ignored.
      cycle(0, 1, 0, 64'hFFFF, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      check("r0_read", rdata0, 64'd0);
      check("r0_busy", 64'(busy[0]), 64'd0);

      // Scoreboard sequence on r4.
      cycle(0, 0, 0, 0, 1, 4, 0, 0);
      check("r4_busy", 64'(busy), 64'h10);
      reset = 0; wen = 0; issue_en = 0; raddr0 = 4; raddr1 = 0; #1;
      check("r4_hazard", 64'(hazard), 64'd1);
      cycle(0, 1, 4, 64'h1234, 0, 0, 4, 0);
      check("r4_cleared", 64'(busy), 64'h00);
      check("r4_bypass", rdata0, 64'h1234);

      // Simultaneous set and clear on r6: set wins.
      cycle(0, 1, 6, 64'hABCD, 1, 6, 6, 3);
      check("r6_set_wins", 64'(busy[6]), 64'd1);
      cycle(1, 1, 2, 64'h77, 1, 2, 6, 3);
      check("midreset_busy", 64'(busy), 64'h00);
      check("midreset_rdata1", rdata1, 64'd0);
      cycle(0, 0, 0, 0, 0, 0, 6, 3);
      check("after_reset_r6", rdata0, 64'd0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 99) < 2),
               ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), {$urandom, $urandom},
               ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_8x64.md
# regfile_8x64

Eight-entry, 64-bit register file with a pending-write scoreboard, fed by the 3-bit destination/source register addresses carried down the pipelined datapath. It sits between decode and the pipeline registers. Decode presents source addresses and receives registered operands one cycle later. Writeback returns the destination address and result. A busy-bit scoreboard raises `hazard` so decode stalls while a source register still has a write in flight.

## Interface
Parameters:
- `DATA_WIDTH`, 64, operand/result width.
- `ADDR_WIDTH`, 3, register address width; fixed to match the 3-bit address pipeline registers; depth = 2**ADDR_WIDTH = 8.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `raddr0`  in  ADDR_WIDTH  source A address.
- `raddr1`  in  ADDR_WIDTH  source B address.
- `rdata0`  out  DATA_WIDTH  registered source A data.
- `rdata1`  out  DATA_WIDTH  registered source B data.
- `wen`  in  1  writeback strobe.
- `waddr`  in  ADDR_WIDTH  writeback destination.
- `wdata`  in  DATA_WIDTH  writeback value.
- `issue_en`  in  1  instruction with destination issued this cycle.
- `issue_addr`  in  ADDR_WIDTH  destination of issued instruction.
- `hazard`  out  1  combinational stall request.
- `busy`  out  2**ADDR_WIDTH  scoreboard bit vector, registered.

## Operation
- Register 0 always reads 0.
  - Writes to it are dropped.
  - Issues to it never set `busy[0]`.
- Write port: when `wen` and `waddr`≠0, `mem[waddr]` ← `wdata` at the edge.
- Read ports: at each edge, `rdata0` ← value of `mem[raddr0]`; `rdata1` ← value of `mem[raddr1]`.
- Write-first bypass: if `wen` and `waddr`==`raddrN`≠0 in the same cycle, `rdataN` captures `wdata`, not the old value.
- Scoreboard, per edge, for address a≠0:
  - Set when `issue_en` and `issue_addr`==a.
  - Cleared when `wen` and `waddr`==a.
  - Simultaneous set and clear on the same a: set wins, because a newer write is now in flight.
- `hazard` = OR over N∈{0,1} of (`raddrN`≠0 and `busy[raddrN]` and not (`wen` and `waddr`==`raddrN`)).
  - A same-cycle writeback resolves the hazard through the bypass.
- While `hazard`=1, reads still occur; decode is responsible for discarding them. The block itself never blocks writeback.
- Issue to an already-busy register: the bit stays set. Out-of-order completion is not supported; the pipeline is in-order.

## Timing
- Read latency 1 cycle: the address presented in cycle t gives data valid on `rdataN` in cycle t+1.
- Write visible to the array at edge t+1; a read of the same address in cycle t+1 returns the new value.
- `hazard` is purely combinational from current inputs and registered `busy`; no added latency.
- Reset (synchronous, any cycle, including mid-operation) sets the following on the next edge:
  - all `mem` entries = 0
  - `rdata0` = `rdata1` = 0
  - `busy` = 0, so `hazard` = 0
- While `reset` is high, `wen` and `issue_en` are ignored.
- First cycle after reset deasserts: normal operation; a read returns 0.

## Structure
- Shared package `regfile_pkg` holds:
  - `DATA_WIDTH`, `ADDR_WIDTH`, `NUM_REGS` (=8), `ZERO_REG` (=0)
  - the `reg_addr_t` (3-bit) and `reg_data_t` (64-bit) typedefs
- All pipeline-register stages use the same package widths.
- One sub-module: `reg_scoreboard` holds the busy vector, the set/clear priority logic and the `hazard` equation.
- The top level holds the storage array, the read registers and the bypass muxes.

## Test plan
- Reset then read r1/r2 → `rdata0`=`rdata1`=0, `busy`=8'h00, `hazard`=0.
- Write r3 ← 64'hDEAD_BEEF_0000_0001; next cycle `raddr0`=3 → `rdata0`=64'hDEAD_BEEF_0000_0001 one cycle later.
- Same-cycle write r5 ← 64'h55 with `raddr1`=5 → next cycle `rdata1`=64'h55 (bypass).
- Write r0 ← 64'hFFFF then read r0 → `rdata0`=0; issue to r0 → `busy[0]` stays 0.
- Scoreboard sequence:
  - `issue_en` r4 → `busy`=8'h10.
  - Next cycle `raddr0`=4 → `hazard`=1.
  - `wen` r4 with `raddr0`=4 → `hazard`=0; next cycle `busy`=8'h00.
- Same-cycle `issue_en` r6 and `wen` r6 → `busy[6]`=1 after the edge. Then `reset` asserted mid-sequence → `busy`=0, `rdata*`=0 next cycle.
